fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO port arbiters.
package fifo_arb_pkg;

    // Arbiter FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Default sizing
    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_MAX_BURST  = 4;

    // Legal parameter ranges
    localparam int unsigned MIN_NUM_REQ     = 2;
    localparam int unsigned MAX_NUM_REQ     = 8;
    localparam int unsigned MIN_BURST_LIMIT = 1;
    localparam int unsigned MAX_BURST_LIMIT = 16;

    // Index width for a requester vector; never below one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan from farthest to nearest so the nearest active requester wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req[IDX_W'((32'(last_grant) + 32'(off)) % NUM_REQ)]) begin
                winner = IDX_W'((32'(last_grant) + 32'(off)) % NUM_REQ);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async FIFO write port.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned MAX_BURST  = DEF_MAX_BURST,
    localparam int unsigned BURST_W    = $clog2(MAX_BURST + 1),
    localparam int unsigned IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                          write_clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          write_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          busy
);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);

    // Reject out-of-range configurations at elaboration
    if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("fifo_write_arbiter: NUM_REQ out of range");
    end
    if (MAX_BURST < MIN_BURST_LIMIT || MAX_BURST > MAX_BURST_LIMIT) begin : g_bad_burst
        $error("fifo_write_arbiter: MAX_BURST out of range");
    end

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [BURST_W-1:0]   burst_cnt;
    logic [BURST_W-1:0]   burst_nxt;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     last_nxt;
    logic                 busy_nxt;
    logic [IDX_W-1:0]     winner;
    logic                 pick_valid;
    logic                 xfer;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    // Unpack requester words; in GRANT last_grant is the owner index
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (pick_valid)
    );

    // A word moves when the owner still presents it and the FIFO has room
    assign xfer = (state == GRANT) && req[last_grant] && !write_full;

    // State register
    always_ff @(posedge write_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, burst counter, priority pointer and busy flag
    always_ff @(posedge write_clock) begin
        if (reset) begin
            grant      <= '0;
            burst_cnt  <= '0;
            last_grant <= LAST_IDX;
            busy       <= 1'b0;
        end else begin
            grant      <= grant_nxt;
            burst_cnt  <= burst_nxt;
            last_grant <= last_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state: pick a new owner from IDLE, end grants on burst limit or req drop
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        burst_nxt = burst_cnt;
        last_nxt  = last_grant;
        busy_nxt  = busy;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = GRANT;
                    grant_nxt = NUM_REQ'(1) << winner;
                    last_nxt  = winner;
                    burst_nxt = '0;
                    busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                if (!req[last_grant]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                end else if (xfer) begin
                    burst_nxt = burst_cnt + BURST_W'(1);
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Write-port outputs; reset suppresses any write in the same cycle
    always_comb begin
        write_enable = 1'b0;
        ack          = '0;
        write_data   = '0;
        if (state == GRANT) begin
            write_data = words[last_grant];
        end
        if (xfer && !reset) begin
            write_enable = 1'b1;
            ack          = NUM_REQ'(1) << last_grant;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a transaction-level model.
module tb_fifo_write_arbiter;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned MAX_BURST  = 4;

    logic                          write_clock = 1'b0;
    logic                          reset;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          write_full;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            ack;
    logic                          write_enable;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          busy;

    fifo_write_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DATA_WIDTH),
        .MAX_BURST    (MAX_BURST)
    ) dut (
        .write_clock  (write_clock),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .write_full   (write_full),
        .grant        (grant),
        .ack          (ack),
        .write_enable (write_enable),
        .write_data   (write_data),
        .busy         (busy)
    );

    always #5 write_clock = ~write_clock;

    int checks   = 0;
    int failures = 0;

    // Model: owner of the port (-1 when idle), words moved in this grant, last owner
    int owner;
    int moved;
    int last;
    int grants_seen;
    logic [DATA_WIDTH-1:0] word     [NUM_REQ];
    bit                    has_word [NUM_REQ];
    bit                    hide     [NUM_REQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input bit rst, input bit full);
        int exp_ack;
        bit xfer;
        @(negedge write_clock);
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = has_word[i] && !hide[i];
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = word[i];
        end
        reset      = rst;
        write_full = full;
        #1;
        xfer    = (owner >= 0) && req[owner] && !full && !rst;
        exp_ack = xfer ? (1 << owner) : 0;
        check_eq("grant", 32'(grant), (owner >= 0) ? 32'(1 << owner) : 32'd0);
        check_eq("busy", 32'(busy), (owner >= 0) ? 32'd1 : 32'd0);
        check_eq("write_enable", 32'(write_enable), xfer ? 32'd1 : 32'd0);
        check_eq("ack", 32'(ack), 32'(exp_ack));
        check_eq("write_data", 32'(write_data), (owner >= 0) ? 32'(word[owner]) : 32'd0);

        if (rst) begin
            owner = -1;
            moved = 0;
            last  = NUM_REQ - 1;
        end else if (owner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (owner < 0 && req[(last + k) % NUM_REQ]) begin
                    owner = (last + k) % NUM_REQ;
                end
            end
            if (owner >= 0) begin
                last  = owner;
                moved = 0;
                grants_seen++;
            end
        end else if (!req[owner]) begin
            owner = -1;
        end else if (!full) begin
            moved++;
            if (moved == MAX_BURST) owner = -1;
        end

        // Requesters advance only on their own acknowledge
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_ack[i]) begin
                word[i]     = DATA_WIDTH'($urandom);
                has_word[i] = ($urandom_range(0, 9) < 7);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_data   = '0;
        write_full = 1'b0;
        owner       = -1;
        moved       = 0;
        last        = NUM_REQ - 1;
        grants_seen = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            word[i]     = DATA_WIDTH'($urandom);
            has_word[i] = 1'b0;
            hide[i]     = 1'b0;
        end
        repeat (2) @(posedge write_clock);
        repeat (2) step(1'b1, 1'b0);

        // Everyone requesting continuously, no backpressure: pure rotation
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NUM_REQ; i++) has_word[i] = 1'b1;
            step(1'b0, 1'b0);
        end

        // Reset mid-traffic, then all requesting again: requester 0 first
        step(1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NUM_REQ; i++) has_word[i] = 1'b1;
            step(1'b0, (c % 7) == 3);
        end

        // Random traffic, backpressure, early drops and occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!has_word[i] && $urandom_range(0, 9) < 3) begin
                    has_word[i] = 1'b1;
                    word[i]     = DATA_WIDTH'($urandom);
                end
                hide[i] = ($urandom_range(0, 19) == 0);
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0);
        end

        // Progress sanity: the arbiter actually issued a healthy number of grants
        checks++;
        if (grants_seen < 200) begin
            failures++;
            $display("FAIL grant_count got=%0d exp>=200", grants_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
